// File: rtl/btn_pkg.sv
// Shared encodings for the button event controller.
// The state values are visible on o_state for debug, so they are fixed here.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } btn_state_e;

endpackage

// File: rtl/button_event_ctrl_tick_gen.sv
// tick_gen: free-running prescaler that produces a one-cycle timing tick.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   o_tick  : high for one i_clk cycle every TICK_DIV cycles
module tick_gen #(
    parameter int TICK_DIV  = 1000,
    parameter int CNT_WIDTH = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TICK_DIV - 1);

    logic [CNT_WIDTH-1:0] pre_q, pre_d;

    // With TICK_DIV=1 LAST is 0, so pre_q stays 0 and o_tick is always high.
    assign o_tick = (pre_q == LAST);
    assign pre_d  = o_tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pre_q <= '0;
        else          pre_q <= pre_d;
    end

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: classifies a debounced button into short click,
// double click, long press and auto-repeat events.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_button       : debounced, synchronised, active-high level
//   o_short        : one-cycle pulse, single short click
//   o_double       : one-cycle pulse, double click
//   o_long         : one-cycle pulse, hold reached LONG_TICKS
//   o_repeat       : one-cycle pulse, auto-repeat while held
//   o_state        : current FSM state (debug)
module button_event_ctrl
    import btn_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int CNT_WIDTH    = 16,
    parameter int LONG_TICKS   = 500,
    parameter int DCLICK_TICKS = 250,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_button,
    output logic       o_short,
    output logic       o_double,
    output logic       o_long,
    output logic       o_repeat,
    output logic [2:0] o_state
);

    localparam logic [CNT_WIDTH-1:0] LONG_C   = CNT_WIDTH'(LONG_TICKS);
    localparam logic [CNT_WIDTH-1:0] DCLICK_C = CNT_WIDTH'(DCLICK_TICKS);
    localparam logic [CNT_WIDTH-1:0] REPEAT_C = CNT_WIDTH'(REPEAT_TICKS);

    btn_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 prev_q;
    logic                 short_q, short_d;
    logic                 double_q, double_d;
    logic                 long_q, long_d;
    logic                 repeat_q, repeat_d;
    logic                 tick, press, release_e;
    logic                 reach_long, reach_dclick, reach_rep;

    tick_gen #(
        .TICK_DIV  (TICK_DIV),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    assign press     =  i_button & ~prev_q;
    assign release_e = ~i_button &  prev_q;

    // Saturate instead of wrapping so a stale count can never re-match.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // "Reaching" a threshold means this tick moves the count onto it.
    assign reach_long   = tick && (cnt_inc == LONG_C);
    assign reach_dclick = tick && (cnt_inc == DCLICK_C);
    assign reach_rep    = tick && (cnt_inc == REPEAT_C);

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? cnt_inc : cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        // Edges are tested before thresholds: the edge wins a same-cycle tie.
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (press) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (release_e) state_d = ST_GAP;
                else if (reach_long) begin
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (press) state_d = ST_PRESS2;
                else if (reach_dclick) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (release_e) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (reach_long) begin
                    // The earlier click is dropped; the hold takes over.
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (release_e) state_d = ST_IDLE;
                else if (reach_rep) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            // Starts high so a button held through reset is not a press.
            prev_q   <= 1'b1;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= i_button;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign o_short  = short_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_repeat = repeat_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl with TICK_DIV=1, LONG=8, DCLICK=4,
// REPEAT=3. Stimulus pushes expected pulses (kind, edge index); a monitor
// compares every pulse the DUT raises against the queue front.
module tb_button_event_ctrl;

    localparam int K_SHORT = 0, K_DOUBLE = 1, K_LONG = 2, K_REPEAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       o_short, o_double, o_long, o_repeat;
    logic [2:0] o_state;

    button_event_ctrl #(
        .TICK_DIV     (1),
        .CNT_WIDTH    (16),
        .LONG_TICKS   (8),
        .DCLICK_TICKS (4),
        .REPEAT_TICKS (3)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_button (btn),
        .o_short  (o_short),
        .o_double (o_double),
        .o_long   (o_long),
        .o_repeat (o_repeat),
        .o_state  (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    int n_p, k_p;
    always @(posedge clk) begin
        #1;
        n_p = int'(o_short) + int'(o_double) + int'(o_long) + int'(o_repeat);
        k_p = o_short ? K_SHORT : o_double ? K_DOUBLE : o_long ? K_LONG : K_REPEAT;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            chk("missing_pulse_kind", -1, sb[0].kind);
            void'(sb.pop_front());
        end
        if (n_p > 1) chk("one_pulse_per_cycle", n_p, 1);
        else if (n_p == 1) begin
            if (sb.size() == 0) chk("unexpected_pulse_kind", k_p, -1);
            else begin
                chk("pulse_kind", k_p, sb[0].kind);
                chk("pulse_edge", cyc, sb[0].at);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int c, p;
    initial begin
        // Reset state
        step(2);
        chk("rst_state", int'(o_state), 0);
        chk("rst_pulses", int'({o_short, o_double, o_long, o_repeat}), 0);
        rst_n = 1'b1;
        step(3);

        // Short click: press 3 cycles, release, short 4 edges after release
        btn = 1'b1; c = cyc;
        step(3);
        btn = 1'b0;
        expect_ev(K_SHORT, c + 8);
        step(1);
        chk("short_gap_state", int'(o_state), 2);
        step(12);

        // Double click
        btn = 1'b1; c = cyc;
        step(2);
        btn = 1'b0;
        step(1);
        chk("dbl_gap_state", int'(o_state), 2);
        step(1);
        btn = 1'b1;
        step(1);
        chk("dbl_press2_state", int'(o_state), 3);
        step(1);
        btn = 1'b0;
        expect_ev(K_DOUBLE, c + 7);
        step(1);
        chk("dbl_idle_state", int'(o_state), 0);
        step(8);

        // Long press with auto-repeat
        btn = 1'b1; c = cyc; p = c + 1;
        expect_ev(K_LONG, p + 8);
        expect_ev(K_REPEAT, p + 11);
        expect_ev(K_REPEAT, p + 14);
        expect_ev(K_REPEAT, p + 17);
        expect_ev(K_REPEAT, p + 20);
        step(9);
        chk("long_hold_state", int'(o_state), 4);
        step(12);
        btn = 1'b0;
        step(1);
        chk("hold_release_state", int'(o_state), 0);
        step(6);

        // Release on the same edge the count reaches LONG: release wins
        btn = 1'b1; c = cyc; p = c + 1;
        step(8);
        btn = 1'b0;
        expect_ev(K_SHORT, p + 12);
        step(1);
        chk("tie_gap_state", int'(o_state), 2);
        step(8);

        // Button held across reset release is ignored
        rst_n = 1'b0;
        btn = 1'b1;
        step(2);
        chk("held_rst_state", int'(o_state), 0);
        rst_n = 1'b1;
        step(20);
        chk("held_after_20_state", int'(o_state), 0);
        btn = 1'b0;
        step(2);
        chk("held_release_state", int'(o_state), 0);
        btn = 1'b1; c = cyc;
        step(1);
        chk("held_repress_state", int'(o_state), 1);
        btn = 1'b0;
        expect_ev(K_SHORT, c + 6);
        step(8);

        // Asynchronous reset in GAP abandons the sequence
        btn = 1'b1;
        step(2);
        btn = 1'b0;
        step(2);
        chk("async_pre_gap_state", int'(o_state), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(o_state), 0);
        chk("async_rst_pulses", int'({o_short, o_double, o_long, o_repeat}), 0);
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("async_after_state", int'(o_state), 0);

        step(2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, meaning i_clk cycles per timing tick (>=1).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of the tick and prescaler counters.
REQ-003 SHALL have parameter LONG_TICKS, default 500, meaning hold ticks that qualify a long press (>=2).
REQ-004 SHALL have parameter DCLICK_TICKS, default 250, meaning maximum release-to-press gap, in ticks, for a double click (>=2).
REQ-005 SHALL have parameter REPEAT_TICKS, default 100, meaning auto-repeat period, in ticks, while held after a long press (>=1).
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_button, input, 1 bit: debounced, synchronised, active-high button level from the debouncer.
REQ-009 SHALL have port o_short, output, 1 bit: one-cycle pulse for a single short click.
REQ-010 SHALL have port o_double, output, 1 bit: one-cycle pulse for a double click.
REQ-011 SHALL have port o_long, output, 1 bit: one-cycle pulse when a hold reaches LONG_TICKS.
REQ-012 SHALL have port o_repeat, output, 1 bit: one-cycle auto-repeat pulse.
REQ-013 SHALL have port o_state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-014 SHALL generate an internal tick for one i_clk cycle every TICK_DIV cycles from a free-running prescaler (TICK_DIV=1 means every cycle).
REQ-015 SHALL detect a press as i_button=1 while the registered previous level is 0, and a release as i_button=0 while the registered previous level is 1.
REQ-016 SHALL implement the states IDLE=0, PRESS1=1, GAP=2, PRESS2=3 and HOLD=4.
REQ-017 SHALL clear the tick counter on every state entry and increment it only on ticks.
REQ-018 SHALL go IDLE->PRESS1 on a press; IDLE SHALL ignore ticks.
REQ-019 SHALL go PRESS1->GAP on a release; on a tick that makes the count reach LONG_TICKS while held, it SHALL pulse o_long and go PRESS1->HOLD.
REQ-020 SHALL go GAP->PRESS2 on a press; on a tick that makes the count reach DCLICK_TICKS with no press, it SHALL pulse o_short and go GAP->IDLE.
REQ-021 SHALL pulse o_double and go PRESS2->IDLE on a release; on reaching LONG_TICKS while held, it SHALL pulse o_long and go PRESS2->HOLD, discarding the first click with no o_short.
REQ-022 SHALL pulse o_repeat in HOLD on every tick that makes the count reach REPEAT_TICKS, then restart the count at 0; a release SHALL go HOLD->IDLE with no pulse.
REQ-023 SHALL give priority to the button edge when an edge and a count-reaching tick occur in the same cycle: release wins in PRESS1/PRESS2, press wins in GAP.
REQ-024 SHALL register all pulse outputs: each asserts exactly one cycle, in the cycle after the edge where its condition was sampled, with at most one pulse asserted per cycle.
REQ-025 SHALL saturate the tick counter at all-ones rather than wrapping; CNT_WIDTH SHALL hold max(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS, TICK_DIV).

Reset
REQ-026 SHALL, on i_rst_n low, immediately force the state to IDLE, both counters to 0, and o_short, o_double, o_long and o_repeat to 0, so o_state=0.
REQ-027 SHALL reset the previous-level register to 1, so a button held across reset release is ignored until it is released and pressed again.
REQ-028 SHALL abandon any sequence in progress when reset is asserted mid-operation, with no pulse emitted.

Structure
REQ-029 SHALL place the state encoding constants in a shared package, btn_pkg.
REQ-030 SHALL implement the prescaler as sub-module tick_gen (params TICK_DIV, CNT_WIDTH; ports i_clk, i_rst_n, o_tick), and keep the FSM and tick counter in button_event_ctrl.

Verification
All scenarios use TICK_DIV=1, LONG_TICKS=8, DCLICK_TICKS=4, REPEAT_TICKS=3.
REQ-031 SHALL verify: press 3 cycles, release, idle 10 -> one o_short exactly 4 cycles after the release is sampled; no other pulses.
REQ-032 SHALL verify: press 2, release 2, press 2, release -> one o_double in the cycle after the second release; no o_short.
REQ-033 SHALL verify: hold 20 cycles -> o_long 8 cycles after the press, then o_repeat every 3 cycles (4 pulses); release -> IDLE with no pulse.
REQ-034 SHALL verify: press, then release in the same cycle the count reaches 8 -> no o_long; GAP entered (o_state=2).
REQ-035 SHALL verify: button held while i_rst_n deasserts, hold 20 cycles -> no pulses and o_state=0; release then press -> PRESS1.
REQ-036 SHALL verify: i_rst_n asserted in GAP -> all outputs 0 and o_state=0 immediately (asynchronously); no o_short afterwards.
